// File: rtl/button_pkg.sv
// button_pkg: shared types and helpers for the push-button conditioner.
package button_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, REPEAT} btn_state_t;
    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction
endpackage

// File: rtl/button_channel.sv
// button_channel: synchroniser, stability-counter debouncer and press/repeat/release FSM for one button.
module button_channel
    import button_pkg::*;
#(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pressed,
    output logic set,
    output logic held,
    output logic released
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [SYNC_STAGES-1:0] sr;
    logic [CW-1:0] cnt;
    logic [RW-1:0] rc;
    btn_state_t state;
    logic s, flip, rise, fall;

    assign s    = sr[SYNC_STAGES-1];
    assign flip = (s != held) && (cnt == CNT_LAST);
    assign rise = flip & s;
    assign fall = flip & ~s;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr   <= '0;
            cnt  <= '0;
            held <= 1'b0;
        end else begin
            sr   <= {sr[SYNC_STAGES-2:0], pressed};
            cnt  <= (s == held || flip) ? '0 : cnt + CW'(1);
            held <= flip ? s : held;
        end
    end

    // A falling held level pre-empts any press or repeat pulse due in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rc       <= '0;
            set      <= 1'b0;
            released <= 1'b0;
        end else begin
            set      <= 1'b0;
            released <= 1'b0;
            if (fall) begin
                state    <= IDLE;
                rc       <= '0;
                released <= 1'b1;
            end else begin
                case (state)
                    IDLE: if (rise) begin
                        set   <= 1'b1;
                        rc    <= '0;
                        state <= WAIT;
                    end
                    WAIT: if (rc != DLY_LAST) begin
                        rc <= rc + RW'(1);
                    end else if (REPEAT_EN != 0) begin
                        set   <= 1'b1;
                        rc    <= '0;
                        state <= REPEAT;
                    end
                    REPEAT: if (rc == PER_LAST) begin
                        set <= 1'b1;
                        rc  <= '0;
                    end else begin
                        rc <= rc + RW'(1);
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: rtl/button_array.sv
// button_array: N independent push-button conditioners sharing one clock and reset.
module button_array #(
    parameter int N               = 4,
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 16,
    parameter int REPEAT_PERIOD   = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] pressed,
    output logic [N-1:0] set,
    output logic [N-1:0] held,
    output logic [N-1:0] released
);
    for (genvar i = 0; i < N; i++) begin : g_ch
        button_channel #(
            .SYNC_STAGES    (SYNC_STAGES),
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (REPEAT_EN),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_PERIOD  (REPEAT_PERIOD)
        ) u_ch (
            .clk     (clk),
            .rst_n   (rst_n),
            .pressed (pressed[i]),
            .set     (set[i]),
            .held    (held[i]),
            .released(released[i])
        );
    end
endmodule

// File: tb/tb_button_array.sv
// tb_button_array: directed and random presses on a repeating and a non-repeating instance against a window/arithmetic model.
module tb_button_array;
    localparam int N    = 4;
    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int RD   = 16;
    localparam int RP   = 4;
    localparam int MAXT = 4096;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    logic [N-1:0] pressed = '0;
    logic [N-1:0] set_r, held_r, rel_r, set_o, held_o, rel_o;

    always #5 clk = ~clk;

    button_array #(.N(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(1),
                   .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_rep (
        .clk(clk), .rst_n(rst_n), .pressed(pressed), .set(set_r), .held(held_r), .released(rel_r));

    button_array #(.N(N), .SYNC_STAGES(SYNC), .DEBOUNCE_CYCLES(DEB), .REPEAT_EN(0),
                   .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)) dut_one (
        .clk(clk), .rst_n(rst_n), .pressed(pressed), .set(set_o), .held(held_o), .released(rel_o));

    int errors = 0;
    int checks = 0;
    int t = 0;
    int t0 = 1;
    bit hist [N][MAXT];
    logic [N-1:0] m_held = '0;
    int m_p [N];
    int rem [N];

    task automatic chk(input string tag, input logic [N-1:0] got, input logic [N-1:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s t=%0d got=%b exp=%b", tag, t, got, exp);
        end
    endtask

    // Raw input sampled at edge k; everything before the last reset release reads as 0.
    function automatic bit px(input int ch, input int k);
        if (k < t0) return 1'b0;
        return hist[ch][k];
    endfunction

    task automatic step();
        logic [N-1:0] e_set_r, e_set_o, e_rel;
        bit flip;
        int d;
        @(posedge clk);
        t++;
        e_set_r = '0;
        e_set_o = '0;
        e_rel   = '0;
        for (int c = 0; c < N; c++) hist[c][t] = pressed[c];
        for (int c = 0; c < N; c++) begin
            flip = 1'b1;
            for (int j = 0; j < DEB; j++)
                if (px(c, t - SYNC - j) == m_held[c]) flip = 1'b0;
            if (flip && !m_held[c]) begin
                m_held[c]  = 1'b1;
                m_p[c]     = t;
                e_set_r[c] = 1'b1;
                e_set_o[c] = 1'b1;
            end else if (flip) begin
                m_held[c] = 1'b0;
                e_rel[c]  = 1'b1;
            end else if (m_held[c]) begin
                d = t - m_p[c];
                e_set_r[c] = (d == RD) || (d > RD && (d - RD) % RP == 0);
            end
        end
        #1;
        chk("set_rep", set_r, e_set_r);
        chk("held_rep", held_r, m_held);
        chk("rel_rep", rel_r, e_rel);
        chk("set_one", set_o, e_set_o);
        chk("held_one", held_o, m_held);
        chk("rel_one", rel_o, e_rel);
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        #1;
        chk("rst_set_rep", set_r, '0);
        chk("rst_held_rep", held_r, '0);
        chk("rst_rel_rep", rel_r, '0);
        chk("rst_set_one", set_o, '0);
        chk("rst_held_one", held_o, '0);
        chk("rst_rel_one", rel_o, '0);
        m_held = '0;
        repeat (cycles) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        t0 = t + 1;
    endtask

    initial begin
        #1;
        do_reset(3);
        steps(3);
        pressed[0] = 1'b1; steps(10);
        pressed[0] = 1'b0; steps(15);
        pressed[1] = 1'b1; steps(3);
        pressed[1] = 1'b0; steps(15);
        pressed[2] = 1'b1; steps(40);
        pressed[2] = 1'b0; steps(15);
        // Held falls exactly when the second repeat pulse would be due.
        pressed[2] = 1'b1; steps(20);
        pressed[2] = 1'b0; steps(15);
        pressed[3] = 1'b1; steps(12);
        do_reset(2);
        steps(12);
        do_reset(4);
        steps(12);
        pressed[3] = 1'b0; steps(15);
        pressed = '1; steps(30);
        pressed = '0; steps(15);
        for (int c = 0; c < N; c++) rem[c] = 0;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    pressed[c] = ~pressed[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : $urandom_range(4, 40);
                end
                rem[c]--;
            end
            if (i == 700) do_reset($urandom_range(1, 4));
            step();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
